register_sequencer: RTL and testbench
=====================================

Name: register_sequencer

Overview:
Control unit that drives the 3-bit register command buses (Tx, Ty, Tz) and the ALU operation select of the 4-bit datapath.
- Accepts one instruction per start/done handshake.
- Decodes the opcode and issues the multi-cycle command sequence to the X, Y and Z registers.
- Counts completed instructions.
- Sits between the instruction source (program/testbench) and the register file/ALU.

Parameters:
CNT_W, 8, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to execute opcode; sampled only in IDLE
opcode  input  4  instruction; captured on the accepting edge
busy  output  1  high from accept until return to IDLE
done  output  1  one-cycle pulse in DONE state
err  output  1  valid while done=1; 1 = illegal opcode
Tx  output  3  X register command
Ty  output  3  Y register command
Tz  output  3  Z register command
alu_sel  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or
retired  output  CNT_W  count of legal instructions completed

Behaviour:
- Register commands: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100. Codes 101–111 are never driven.
- All outputs are decoded from state plus the latched opcode only. There is no combinational path from start or opcode to any output.
- Reset (rst_n=0, asynchronous):
  - state IDLE; opcode latch 0000; retired 0.
  - Tx=Ty=Tz=HOLD; alu_sel 00; busy 0; done 0; err 0.
  - Effective immediately, without a clock edge.
- Reset mid-instruction: the instruction is discarded and no done is generated. Release of rst_n resumes from IDLE.
- States: IDLE, DECODE, EXEC1, EXEC2, DONE, encoded in 3 bits. Unused encodings go to IDLE on the next edge.
- IDLE:
  - busy 0; all commands HOLD.
  - If start=1 at an edge: latch opcode, go to DECODE.
- DECODE: busy 1; all HOLD. Legal opcode -> EXEC1; illegal -> DONE with err flag set.
- EXEC1 drives the following; unlisted buses stay HOLD, unlisted alu_sel stays 00:
  - 0000 NOP: nothing.
  - 0001 LDX: Tx=LOAD.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR: Ty=LOAD; alu_sel = opcode-2.
  - 0110 SHR: Tz=SHIFTR.
  - 0111 SHL: Tz=SHIFTL.
  - 1000 CLR: Tx=Ty=Tz=RESET.
  - 1001–1111: illegal.
- EXEC1 transitions: ALU ops (0010–0101) -> EXEC2; all others -> DONE.
- EXEC2: Tz=LOAD; alu_sel held at the EXEC1 value; Tx=Ty=HOLD; -> DONE.
- DONE:
  - done=1; busy=1; all HOLD; err = illegal flag.
  - retired increments on the edge leaving DONE, legal instructions only (NOP counts). Wraps at all-ones to 0.
  - -> IDLE.
- Latency, with start accepted at edge 0:
  - Single-step ops: command asserted cycle 2, done cycle 3.
  - ALU ops: Ty cycle 2, Tz cycle 3, done cycle 4.
  - Illegal opcodes: done cycle 2, no command ever driven.
- Handshake:
  - start while busy is ignored and not queued.
  - start held high continuously gives back-to-back instructions, each accepted in IDLE. The opcode at each IDLE edge is used.
  - The opcode input may change freely after acceptance.
- Exactly one state's commands are visible per cycle. No glitching between non-HOLD codes within a cycle, apart from decode settling after the clock edge.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC2 of ADD -> Tz returns to 000, busy=0, done never pulses. After release, retired=0 and state is IDLE.
- LDX: start=1, opcode=0001 for one cycle -> Tx=001 in cycle 2 only, done=1 and err=0 in cycle 3, retired 0->1.
- SUB: opcode=0011 -> cycle 2 has Ty=001 with alu_sel=01; cycle 3 has Tz=001 with alu_sel=01; done in cycle 4; Tx=000 throughout.
- Illegal: opcode=1010 -> no non-HOLD command on any bus; done=1 and err=1 in cycle 2; retired unchanged.
- Busy ignore and back-to-back:
  - Pulse start with opcode=0110 during busy of a CLR -> only CLR executes (Tx=Ty=Tz=100 once).
  - Hold start=1 with opcode=0111 -> successive Tz=011 pulses at 4-cycle spacing.
- Counter wrap: preload via 255 NOPs, then one more NOP -> retired 11111111 -> 00000000 on the edge leaving DONE.

Source files
------------

// File: rtl/register_sequencer.sv
// Control sequencer for the 4-bit datapath: accepts one opcode per start/done handshake and
// drives the X/Y/Z register command buses and ALU select through a multi-cycle sequence.
module register_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       Tx,
    output logic [2:0]       Ty,
    output logic [2:0]       Tz,
    output logic [1:0]       alu_sel,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] CmdHold   = 3'b000;
    localparam logic [2:0] CmdLoad   = 3'b001;
    localparam logic [2:0] CmdShiftR = 3'b010;
    localparam logic [2:0] CmdShiftL = 3'b011;
    localparam logic [2:0] CmdReset  = 3'b100;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDecode = 3'd1,
        StExec1  = 3'd2,
        StExec2  = 3'd3,
        StDone   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       op_legal;
    logic       op_is_alu;
    logic [1:0] alu_code;

    assign op_legal  = (op_q <= 4'd8);
    assign op_is_alu = (op_q >= 4'd2) && (op_q <= 4'd5);
    // ADD..OR occupy opcodes 2..5; the low two bits minus 2 give the ALU select directly.
    assign alu_code  = op_q[1:0] - 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = StIdle;
        op_d      = op_q;
        retired_d = retired_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = opcode;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = op_legal ? StExec1 : StDone;
            StExec1:  state_d = op_is_alu ? StExec2 : StDone;
            StExec2:  state_d = StDone;
            StDone: begin
                state_d = StIdle;
                if (op_legal) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            // Unused encodings fall back to idle.
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        Tx      = CmdHold;
        Ty      = CmdHold;
        Tz      = CmdHold;
        alu_sel = 2'b00;
        case (state_q)
            StDecode: busy = 1'b1;
            StExec1: begin
                busy = 1'b1;
                case (op_q)
                    4'd1: Tx = CmdLoad;
                    4'd2, 4'd3, 4'd4, 4'd5: begin
                        Ty      = CmdLoad;
                        alu_sel = alu_code;
                    end
                    4'd6: Tz = CmdShiftR;
                    4'd7: Tz = CmdShiftL;
                    4'd8: begin
                        Tx = CmdReset;
                        Ty = CmdReset;
                        Tz = CmdReset;
                    end
                    default: ;
                endcase
            end
            StExec2: begin
                busy    = 1'b1;
                Tz      = CmdLoad;
                alu_sel = alu_code;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
                err  = ~op_legal;
            end
            default: ;
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Randomized and directed bench for register_sequencer, checked cycle by cycle against a
// per-instruction step-table model.
module tb_register_sequencer;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       opcode;
    logic             busy, done, err;
    logic [2:0]       Tx, Ty, Tz;
    logic [1:0]       alu_sel;
    logic [CNT_W-1:0] retired;

    register_sequencer #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .Tx      (Tx),
        .Ty      (Ty),
        .Tz      (Tz),
        .alu_sel (alu_sel),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one active instruction, the step number since acceptance, and the retire count.
    bit m_act = 1'b0;
    int m_op  = 0;
    int m_k   = 0;
    int m_ret = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int inst_len(input int op);
        if (op > 8) return 2;
        if (op >= 2 && op <= 5) return 4;
        return 3;
    endfunction

    // {busy, done, err, Tx, Ty, Tz, alu_sel}
    function automatic logic [13:0] expect_out();
        logic       b, d, e;
        logic [2:0] x, y, z;
        logic [1:0] a;
        b = 0; d = 0; e = 0; x = 0; y = 0; z = 0; a = 0;
        if (m_act) begin
            b = 1;
            if (m_k == inst_len(m_op)) begin
                d = 1;
                e = (m_op > 8);
            end else if (m_k == 2) begin
                case (m_op)
                    1: x = 3'd1;
                    2, 3, 4, 5: begin y = 3'd1; a = 2'(m_op - 2); end
                    6: z = 3'd2;
                    7: z = 3'd3;
                    8: begin x = 3'd4; y = 3'd4; z = 3'd4; end
                    default: ;
                endcase
            end else if (m_k == 3) begin
                z = 3'd1;
                a = 2'(m_op - 2);
            end
        end
        return {b, d, e, x, y, z, a};
    endfunction

    task automatic model_edge();
        if (!m_act) begin
            if (start) begin
                m_act = 1'b1;
                m_op  = int'(opcode);
                m_k   = 1;
            end
        end else if (m_k == inst_len(m_op)) begin
            if (m_op <= 8) m_ret = (m_ret + 1) % (1 << CNT_W);
            m_act = 1'b0;
        end else begin
            m_k++;
        end
    endtask

    // One clock: advance the model at the edge, compare everything at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outs", 32'({busy, done, err, Tx, Ty, Tz, alu_sel}), 32'(expect_out()));
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        m_act = 1'b0;
        m_ret = 0;
        chk("rst_outs", 32'({busy, done, err, Tx, Ty, Tz, alu_sel}), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_done", 32'(done), 32'(0));
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        start = 1'b0;
        while (m_act && guard < 10) begin
            cycle();
            guard++;
        end
        if (m_act) chk("drain_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        int last_hit;
        int guard;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 4'd0;
        #2;
        apply_reset();
        cycle();

        // LDX
        start = 1'b1; opcode = 4'd1;
        cycle();
        start = 1'b0; opcode = 4'(($urandom));
        cycle();
        chk("ldx_tx", 32'(Tx), 32'(1));
        cycle();
        chk("ldx_done_err", 32'({done, err}), 32'(2'b10));
        cycle();
        chk("ldx_retired", 32'(retired), 32'(1));

        // SUB
        start = 1'b1; opcode = 4'd3;
        cycle();
        start = 1'b0;
        cycle();
        chk("sub_c2", 32'({Tx, Ty, Tz, alu_sel}), 32'({3'd0, 3'd1, 3'd0, 2'd1}));
        cycle();
        chk("sub_c3", 32'({Tx, Ty, Tz, alu_sel}), 32'({3'd0, 3'd0, 3'd1, 2'd1}));
        cycle();
        chk("sub_done", 32'(done), 32'(1));
        cycle();

        // Illegal opcode
        start = 1'b1; opcode = 4'd10;
        cycle();
        start = 1'b0;
        cycle();
        chk("ill_done_err", 32'({done, err, Tx, Ty, Tz}), 32'({2'b11, 9'd0}));
        cycle();
        chk("ill_retired", 32'(retired), 32'(2));

        // CLR with an ignored start pulse while busy
        start = 1'b1; opcode = 4'd8;
        cycle();
        opcode = 4'd6;
        cycle();
        start = 1'b0;
        chk("clr_cmds", 32'({Tx, Ty, Tz}), 32'({3'd4, 3'd4, 3'd4}));
        cycle();
        cycle();
        cycle();
        chk("clr_no_shr", 32'({busy, Tz}), 32'(0));

        // Held start with SHL: Tz=SHIFTL every 4 cycles
        start = 1'b1; opcode = 4'd7;
        last_hit = -1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (Tz == 3'd3) begin
                if (last_hit >= 0) chk("shl_spacing", 32'(i - last_hit), 32'(4));
                last_hit = i;
            end
        end
        drain();
        cycle();

        // Reset in EXEC2 of ADD
        start = 1'b1; opcode = 4'd2;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        chk("add_exec2_tz", 32'(Tz), 32'(1));
        #2;
        apply_reset();
        cycle();
        chk("post_rst_idle", 32'({busy, retired}), 32'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            opcode = 4'($urandom_range(0, 15));
            cycle();
        end
        drain();

        // Counter wrap via held-start NOPs
        apply_reset();
        start = 1'b1; opcode = 4'd0;
        guard = 0;
        while (m_ret != 255 && guard < 1100) begin
            cycle();
            guard++;
        end
        chk("wrap_pre", 32'(retired), 32'(255));
        guard = 0;
        while (m_ret != 0 && guard < 10) begin
            cycle();
            if (m_act) start = 1'b0;
            guard++;
        end
        chk("wrap_post", 32'(retired), 32'(0));
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
